// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one async FIFO write port
// among NUM_REQ producers. A grant is held until the owner's packet ends,
// so packets from different producers never interleave in the FIFO.
//
// Optional build macro: FIFO_ARB_BURST_CAP_EN
//   defined   - a grant is also released after MAX_BURST accepted beats;
//               the producer re-requests and resumes its packet later
//   undefined - only the owner's last flag releases the grant
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no owner; pick the next requester starting at r_rr_ptr
// S_GRANT | r_owner holds the write port until its release beat
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                          i_clk,
  input  logic                          i_RST,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_last,
  input  logic                          i_Full_Flag,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_wr_en,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic                          o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef FIFO_ARB_BURST_CAP_EN
  localparam logic L_CAP_EN = 1'b1;
`else
  localparam logic L_CAP_EN = 1'b0;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_owner;
  logic [IDX_W-1:0]        w_owner_nxt;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        w_rr_nxt;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      w_grant_nxt;
  logic [CNT_WIDTH-1:0]    r_beat_cnt;
  logic [CNT_WIDTH-1:0]    w_cnt_nxt;

  logic                    w_found;
  logic [IDX_W-1:0]        w_pick;
  logic [IDX_W-1:0]        w_owner_inc;
  logic                    w_accept;
  logic                    w_cap_hit;
  logic                    w_release;
  logic [DATA_WIDTH-1:0]   w_slice [NUM_REQ];

  // Round-robin search: descending scan so the requester closest to r_rr_ptr wins.
  always_comb begin
    logic [IDX_W:0]   v_sum;
    logic [IDX_W-1:0] v_idx;
    w_found = 1'b0;
    w_pick  = '0;
    v_sum   = '0;
    v_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (v_sum >= (IDX_W+1)'(NUM_REQ)) begin
        v_sum = v_sum - (IDX_W+1)'(NUM_REQ);
      end
      v_idx = v_sum[IDX_W-1:0];
      if (i_req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  // Unpack the producer data bus into per-producer beats for the owner mux.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_slice[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  // Accept is combinational against the same-cycle full flag so no beat is lost.
  assign w_accept  = (r_state == S_GRANT) & i_req[r_owner] & ~i_Full_Flag & ~i_RST;
  assign w_cap_hit = (r_beat_cnt == CNT_WIDTH'(MAX_BURST - 1));
  assign w_release = w_accept & (i_last[r_owner] | (L_CAP_EN & w_cap_hit));

  assign o_wr_en   = w_accept;
  assign o_ack     = w_accept ? (NUM_REQ'(1) << r_owner) : '0;
  assign o_wr_data = (r_state == S_GRANT) ? w_slice[r_owner] : '0;
  assign o_grant   = r_grant;
  assign o_busy    = (r_state == S_GRANT) & ~i_RST;

  // Next-state, owner, round-robin pointer, grant and beat count.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick;
          w_grant_nxt = NUM_REQ'(1) << w_pick;
          w_cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (w_accept) begin
          w_cnt_nxt = r_beat_cnt + CNT_WIDTH'(1);
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = w_owner_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_RST) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=16).
// Inputs change 1 time unit after the rising edge; outputs are compared
// 3 units after the edge, well before the next one.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic        full;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;

  logic [17:0] obs;
  int          n_chk;
  int          n_pass;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16), .CNT_WIDTH(5)
  ) dut (
    .i_clk(clk), .i_RST(rst), .i_req(req), .i_data(data), .i_last(last),
    .i_Full_Flag(full), .o_ack(ack), .o_grant(grant), .o_wr_en(wr_en),
    .o_wr_data(wr_data), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {wr_en, ack, grant, busy, wr_data};

  function automatic logic [17:0] ex(input logic w, input logic [3:0] a,
                                     input logic [3:0] g, input logic b,
                                     input logic [7:0] d);
    return {w, a, g, b, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; last = 4'b1111; data = 32'hA3A2A1A0;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL reset_hold got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
    rst = 1'b0; req = 4'b0000; last = 4'b0000;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL reset_idle got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
  endtask

  task automatic test_single_packet();
    logic [7:0] d;
    req = 4'b0001; data = 32'h00000011; last = 4'b0000;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL single_arb got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
    for (int b = 0; b < 3; b++) begin
      d = 8'h11 * 8'(b + 1);
      data[7:0] = d;
      last[0] = (b == 2);
      #2;
      n_chk++;
      if (obs !== ex(1'b1, 4'b0001, 4'b0001, 1'b1, d))
        $display("FAIL single_beat%0d got %h exp %h", b, obs, ex(1'b1, 4'b0001, 4'b0001, 1'b1, d));
      else n_pass++;
      cyc();
    end
    req = 4'b0000; last = 4'b0000;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL single_release got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
    // rr_ptr should now be 1: with 0 and 1 requesting, 1 wins.
    req = 4'b0011; last = 4'b0011; data = 32'h0000B1B0;
    #2;
    cyc();
    #2;
    n_chk++;
    if (obs !== ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'hB1))
      $display("FAIL single_rrptr got %h exp %h", obs, ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'hB1));
    else n_pass++;
    cyc();
    req = 4'b0000; last = 4'b0000;
    #2;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 4'b1111; last = 4'b1111; data = 32'hA3A2A1A0;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      #2;
      n_chk++;
      if (obs !== 18'h0) $display("FAIL rr_bubble%0d got %h exp %h", g, obs, 18'h0);
      else n_pass++;
      cyc();
      #2;
      n_chk++;
      if (obs !== ex(1'b1, oh, oh, 1'b1, 8'hA0 + 8'(g % 4)))
        $display("FAIL rr_grant%0d got %h exp %h", g, obs, ex(1'b1, oh, oh, 1'b1, 8'hA0 + 8'(g % 4)));
      else n_pass++;
      cyc();
    end
    req = 4'b0000; last = 4'b0000;
    #2;
    cyc();
  endtask

  task automatic test_full();
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 4'b0100; last = 4'b0000; data = 32'h00510000;
    #2;
    cyc();
    #2;
    n_chk++;
    if (obs !== ex(1'b1, 4'b0100, 4'b0100, 1'b1, 8'h51))
      $display("FAIL full_beat0 got %h exp %h", obs, ex(1'b1, 4'b0100, 4'b0100, 1'b1, 8'h51));
    else n_pass++;
    cyc();
    data[23:16] = 8'h52; full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_chk++;
      if (obs !== ex(1'b0, 4'b0000, 4'b0100, 1'b1, 8'h52))
        $display("FAIL full_stall%0d got %h exp %h", c, obs, ex(1'b0, 4'b0000, 4'b0100, 1'b1, 8'h52));
      else n_pass++;
      cyc();
    end
    full = 1'b0;
    for (int b = 2; b <= 4; b++) begin
      data[23:16] = 8'h50 + 8'(b);
      last[2] = (b == 4);
      #2;
      n_chk++;
      if (obs !== ex(1'b1, 4'b0100, 4'b0100, 1'b1, 8'h50 + 8'(b)))
        $display("FAIL full_resume%0d got %h exp %h", b, obs, ex(1'b1, 4'b0100, 4'b0100, 1'b1, 8'h50 + 8'(b)));
      else n_pass++;
      cyc();
    end
    req = 4'b0000; last = 4'b0000;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL full_release got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
  endtask

  task automatic test_owner_drop();
    // rr_ptr is 3 after producer 2 released.
    req = 4'b1001; last = 4'b0001; data = 32'h6100000F;
    #2;
    cyc();
    #2;
    n_chk++;
    if (obs !== ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'h61))
      $display("FAIL drop_beat0 got %h exp %h", obs, ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'h61));
    else n_pass++;
    cyc();
    req = 4'b0001; data[31:24] = 8'h62;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_chk++;
      if (obs !== ex(1'b0, 4'b0000, 4'b1000, 1'b1, 8'h62))
        $display("FAIL drop_gap%0d got %h exp %h", c, obs, ex(1'b0, 4'b0000, 4'b1000, 1'b1, 8'h62));
      else n_pass++;
      cyc();
    end
    req = 4'b1001;
    #2;
    n_chk++;
    if (obs !== ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'h62))
      $display("FAIL drop_beat1 got %h exp %h", obs, ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'h62));
    else n_pass++;
    cyc();
    data[31:24] = 8'h63; last = 4'b1001;
    #2;
    n_chk++;
    if (obs !== ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'h63))
      $display("FAIL drop_beat2 got %h exp %h", obs, ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'h63));
    else n_pass++;
    cyc();
    req = 4'b0001; last = 4'b0001;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL drop_bubble got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
    #2;
    n_chk++;
    if (obs !== ex(1'b1, 4'b0001, 4'b0001, 1'b1, 8'h0F))
      $display("FAIL drop_next got %h exp %h", obs, ex(1'b1, 4'b0001, 4'b0001, 1'b1, 8'h0F));
    else n_pass++;
    cyc();
    req = 4'b0000; last = 4'b0000;
    #2;
    cyc();
  endtask

  task automatic test_reset_mid();
    // rr_ptr is 1 here, so producer 1 takes the first grant.
    req = 4'b0011; last = 4'b0000; data = 32'h00008170;
    #2;
    cyc();
    for (int b = 0; b < 2; b++) begin
      #2;
      n_chk++;
      if (obs !== ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'h81))
        $display("FAIL rstmid_beat%0d got %h exp %h", b, obs, ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'h81));
      else n_pass++;
      cyc();
    end
    rst = 1'b1;
    #2;
    n_chk++;
    if ({wr_en, ack, busy} !== 6'b0)
      $display("FAIL rstmid_during got %b exp %b", {wr_en, ack, busy}, 6'b0);
    else n_pass++;
    cyc();
    rst = 1'b0;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL rstmid_idle got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
    last = 4'b0001;
    #2;
    n_chk++;
    if (obs !== ex(1'b1, 4'b0001, 4'b0001, 1'b1, 8'h70))
      $display("FAIL rstmid_req0 got %h exp %h", obs, ex(1'b1, 4'b0001, 4'b0001, 1'b1, 8'h70));
    else n_pass++;
    cyc();
    req = 4'b0000; last = 4'b0000;
    #2;
    cyc();
  endtask

  task automatic test_burst();
    int n1;
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 4'b1010; last = 4'b0000; data = 32'hC0000000;
`ifdef FIFO_ARB_BURST_CAP_EN
    n1 = 16;
`else
    n1 = 20;
`endif
    #2;
    cyc();
    for (int i = 0; i < n1; i++) begin
      data[15:8] = 8'h80 + 8'(i);
      last[1] = (i == 19);
      #2;
      n_chk++;
      if (obs !== ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'h80 + 8'(i)))
        $display("FAIL burst_p1_beat%0d got %h exp %h", i, obs, ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'h80 + 8'(i)));
      else n_pass++;
      cyc();
    end
    last[1] = 1'b0;
    if (n1 == 20) req = 4'b1000;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL burst_bubble got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
    for (int j = 0; j < 2; j++) begin
      data[31:24] = 8'hC0 + 8'(j);
      last[3] = (j == 1);
      #2;
      n_chk++;
      if (obs !== ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'hC0 + 8'(j)))
        $display("FAIL burst_p3_beat%0d got %h exp %h", j, obs, ex(1'b1, 4'b1000, 4'b1000, 1'b1, 8'hC0 + 8'(j)));
      else n_pass++;
      cyc();
    end
    last = 4'b0000;
    req[3] = 1'b0;
    #2;
    cyc();
    for (int i = n1; i < 20; i++) begin
      data[15:8] = 8'h80 + 8'(i);
      last[1] = (i == 19);
      #2;
      n_chk++;
      if (obs !== ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'h80 + 8'(i)))
        $display("FAIL burst_p1_tail%0d got %h exp %h", i, obs, ex(1'b1, 4'b0010, 4'b0010, 1'b1, 8'h80 + 8'(i)));
      else n_pass++;
      cyc();
    end
    req = 4'b0000; last = 4'b0000;
    #2;
    n_chk++;
    if (obs !== 18'h0) $display("FAIL burst_end got %h exp %h", obs, 18'h0);
    else n_pass++;
    cyc();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; req = '0; data = '0; last = '0; full = 1'b0;
    cyc();
    cyc();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full();
    test_owner_drop();
    test_reset_mid();
    test_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
